// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the instruction-memory request/response bus, the
// redirect request and the decode-side valid/ready handshake of fetch_queue.
//   master : the fetch unit (drives mem_req/mem_addr and all ir_* outputs)
//   slave  : the environment (memory, branch unit, decode)
// Parameters: XLEN (address width), DEPTH (queue entries, sets occupancy width).
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             mem_req;
  logic [XLEN-1:0]  mem_addr;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             ir_valid;
  logic             ir_ready;
  logic [XLEN-1:0]  ir_pc;
  logic [31:0]      ir_instr;
  logic [6:0]       ir_op;
  logic [4:0]       ir_rd;
  logic [2:0]       ir_func3;
  logic [4:0]       ir_rs1;
  logic [4:0]       ir_rs2;
  logic [6:0]       ir_func7;
  logic [24:0]      ir_extend;
  logic [CNT_W-1:0] occupancy;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  redirect_valid, redirect_pc,
    output ir_valid, ir_pc, ir_instr, ir_op, ir_rd, ir_func3,
    output ir_rs1, ir_rs2, ir_func7, ir_extend, occupancy,
    input  ir_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    output redirect_valid, redirect_pc,
    input  ir_valid, ir_pc, ir_instr, ir_op, ir_rd, ir_func3,
    input  ir_rs1, ir_rs2, ir_func7, ir_extend, occupancy,
    output ir_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch unit. Issues word reads to
// instruction memory under a credit limit (buffered + in-flight <= DEPTH),
// keeps the PC of every in-flight request in a tag FIFO, stores returned
// words with their PCs in a DEPTH-entry FIFO, and presents the head entry
// pre-split into RISC-V fields. A redirect flushes everything and restarts
// fetch; responses still in flight at that moment are counted and dropped.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - fetch_queue_if.master (memory bus, redirect, decode handshake,
//           occupancy)
// Optional feature macro: FETCH_BYPASS_EN - when defined, an undropped
// response arriving while the queue is empty is presented to decode in the
// same cycle and, if accepted, never written into the queue.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  // Repeated redirects can stack stale responses beyond DEPTH.
  localparam int DROP_W = 16;

  logic [XLEN-1:0]   fetch_pc_r;
  logic [31:0]       instr_mem_r [DEPTH];
  logic [XLEN-1:0]   pc_mem_r    [DEPTH];
  logic [XLEN-1:0]   tag_mem_r   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  tag_wr_r;
  logic [PTR_W-1:0]  tag_rd_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  inflight_r;
  logic [DROP_W-1:0] drop_r;

  logic              credit_ok_s;
  logic              grant_s;
  logic              rsp_keep_s;
  logic              byp_take_s;
  logic              push_s;
  logic              pop_s;
  logic              ir_valid_s;
  logic [31:0]       ir_instr_s;
  logic [XLEN-1:0]   ir_pc_s;
  logic              unused_s;

  assign unused_s    = ^bus.redirect_pc[1:0];
  assign credit_ok_s = ({1'b0, count_r} + {1'b0, inflight_r}) < (CNT_W + 1)'(DEPTH);
  assign bus.mem_req  = !reset && credit_ok_s && !bus.redirect_valid;
  assign bus.mem_addr = fetch_pc_r;
  assign grant_s      = bus.mem_req && bus.mem_gnt;
  // A response is kept only when no stale responses remain and no redirect is flushing.
  assign rsp_keep_s   = bus.mem_rvalid && (drop_r == DROP_W'(0)) && !bus.redirect_valid;

  // Head-entry selection: FIFO head, optional same-cycle bypass, zeros when empty.
  always_comb begin
    ir_valid_s = 1'b0;
    ir_instr_s = 32'h0000_0000;
    ir_pc_s    = '0;
    byp_take_s = 1'b0;
    if (count_r != CNT_W'(0)) begin
      ir_valid_s = 1'b1;
      ir_instr_s = instr_mem_r[rd_ptr_r];
      ir_pc_s    = pc_mem_r[rd_ptr_r];
    end else begin
`ifdef FETCH_BYPASS_EN
      if (rsp_keep_s) begin
        ir_valid_s = 1'b1;
        ir_instr_s = bus.mem_rdata;
        ir_pc_s    = tag_mem_r[tag_rd_r];
        byp_take_s = bus.ir_ready;
      end else begin
        ir_valid_s = 1'b0;
      end
`else
      ir_valid_s = 1'b0;
`endif
    end
  end

  assign push_s = rsp_keep_s && !byp_take_s;
  assign pop_s  = (count_r != CNT_W'(0)) && bus.ir_ready && !bus.redirect_valid;

  assign bus.ir_valid  = ir_valid_s;
  assign bus.ir_instr  = ir_instr_s;
  assign bus.ir_pc     = ir_pc_s;
  assign bus.ir_op     = ir_instr_s[6:0];
  assign bus.ir_rd     = ir_instr_s[11:7];
  assign bus.ir_func3  = ir_instr_s[14:12];
  assign bus.ir_rs1    = ir_instr_s[19:15];
  assign bus.ir_rs2    = ir_instr_s[24:20];
  assign bus.ir_func7  = ir_instr_s[31:25];
  assign bus.ir_extend = ir_instr_s[31:7];
  assign bus.occupancy = count_r;

  // Fetch PC, queue storage, tag FIFO, and credit/drop bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      tag_wr_r   <= '0;
      tag_rd_r   <= '0;
      count_r    <= '0;
      inflight_r <= '0;
      drop_r     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]    <= '0;
        tag_mem_r[i]   <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Every in-flight request becomes stale; one arriving now is already gone.
      fetch_pc_r <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      tag_wr_r   <= '0;
      tag_rd_r   <= '0;
      count_r    <= '0;
      inflight_r <= '0;
      drop_r     <= drop_r + DROP_W'(inflight_r) - DROP_W'(bus.mem_rvalid);
    end else begin
      if (grant_s) begin
        fetch_pc_r          <= fetch_pc_r + XLEN'(3'd4);
        tag_mem_r[tag_wr_r] <= fetch_pc_r;
        tag_wr_r            <= tag_wr_r + PTR_W'(1'b1);
      end
      if (bus.mem_rvalid && (drop_r != DROP_W'(0))) begin
        drop_r <= drop_r - DROP_W'(1'b1);
      end
      if (rsp_keep_s) begin
        tag_rd_r <= tag_rd_r + PTR_W'(1'b1);
      end
      if (push_s) begin
        instr_mem_r[wr_ptr_r] <= bus.mem_rdata;
        pc_mem_r[wr_ptr_r]    <= tag_mem_r[tag_rd_r];
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      count_r    <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      inflight_r <= inflight_r + CNT_W'(grant_s) - CNT_W'(rsp_keep_s);
    end
  end
endmodule
